// File: rtl/addsub_pkg.sv
// rtl/addsub_pkg.sv - op encoding, flag struct and op helpers for the pipelined add/sub unit
package addsub_pkg;

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_SUB  = 2'b01,
    OP_SLT  = 2'b10,
    OP_SLTU = 2'b11
  } addsub_op_e;

  typedef struct packed {
    logic z;
    logic n;
    logic c;
    logic v;
  } addsub_flags_t;

  // Everything except ADD runs the subtract path (B inverted, carry-in 1).
  function automatic logic op_is_sub(input addsub_op_e op);
    return op != OP_ADD;
  endfunction

  function automatic logic op_is_cmp(input addsub_op_e op);
    return (op == OP_SLT) || (op == OP_SLTU);
  endfunction

endpackage

// File: rtl/addsub_slice.sv
// rtl/addsub_slice.sv - combinational W-bit adder segment with carry-out and MSB carry-in
module addsub_slice #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         cin_msb
);

  logic [W:0] full;

  assign full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
  assign sum  = full[W-1:0];
  assign cout = full[W];
  // Sum bit = a ^ b ^ carry-in, so the carry into the MSB falls out directly.
  assign cin_msb = sum[W-1] ^ a[W-1] ^ b[W-1];

endmodule

// File: rtl/addsub_pipe.sv
// rtl/addsub_pipe.sv - pipelined ADD/SUB/SLT/SLTU unit; flag outputs need ADDSUB_PIPE_FLAGS_EN
module addsub_pipe
  import addsub_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int STAGES     = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  addsub_op_e            op,
  input  logic [DATA_WIDTH-1:0] src_a,
  input  logic [DATA_WIDTH-1:0] src_b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  flag_z,
  output logic                  flag_n,
  output logic                  flag_c,
  output logic                  flag_v
);

  localparam int W = DATA_WIDTH / STAGES;

  if (DATA_WIDTH < 1 || STAGES < 1 || (DATA_WIDTH % STAGES) != 0) begin : g_bad_cfg
    $error("addsub_pipe: DATA_WIDTH must be a positive multiple of STAGES");
  end

  logic                  advance;
  logic                  sub_in;
  logic [DATA_WIDTH-1:0] b_eff;

  assign advance  = ~out_valid | out_ready;
  assign in_ready = advance;
  assign sub_in   = op_is_sub(op);
  assign b_eff    = sub_in ? ~src_b : src_b;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int DONE = (k + 1) * W;
    localparam int PEND = DATA_WIDTH - DONE;

    logic            valid_d;
    logic            valid_q;
    addsub_op_e      op_d;
    logic [W-1:0]    sa;
    logic [W-1:0]    sb;
    logic [W-1:0]    ssum;
    logic            cin;
    logic            cout;
    logic            cmsb;
    logic [DONE-1:0] done_d;

    addsub_slice #(.W(W)) u_slice (
      .a       (sa),
      .b       (sb),
      .cin     (cin),
      .sum     (ssum),
      .cout    (cout),
      .cin_msb (cmsb)
    );

    if (k == 0) begin : g_src
      assign valid_d = in_valid;
      assign op_d    = op;
      assign sa      = src_a[W-1:0];
      assign sb      = b_eff[W-1:0];
      assign cin     = sub_in;
      assign done_d  = ssum;
    end else begin : g_src
      assign valid_d = g_stage[k-1].valid_q;
      assign op_d    = g_stage[k-1].g_mid.op_q;
      assign sa      = g_stage[k-1].g_mid.a_q[W-1:0];
      assign sb      = g_stage[k-1].g_mid.b_q[W-1:0];
      assign cin     = g_stage[k-1].g_mid.carry_q;
      assign done_d  = {ssum, g_stage[k-1].g_mid.done_q};
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        valid_q <= 1'b0;
      end else if (advance) begin
        valid_q <= valid_d;
      end
    end

    if (k < STAGES - 1) begin : g_mid
      // Skew registers carry the still-unadded operand slices; done_q is the deskewed low sum.
      logic [PEND-1:0] a_d;
      logic [PEND-1:0] b_d;
      logic [PEND-1:0] a_q;
      logic [PEND-1:0] b_q;
      logic [DONE-1:0] done_q;
      logic            carry_q;
      addsub_op_e      op_q;
      logic            unused_cmsb;

      assign unused_cmsb = cmsb;

      if (k == 0) begin : g_skew_in
        assign a_d = src_a[DATA_WIDTH-1:W];
        assign b_d = b_eff[DATA_WIDTH-1:W];
      end else begin : g_skew_in
        assign a_d = g_stage[k-1].g_mid.a_q[PEND+W-1:W];
        assign b_d = g_stage[k-1].g_mid.b_q[PEND+W-1:W];
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          a_q     <= '0;
          b_q     <= '0;
          done_q  <= '0;
          carry_q <= 1'b0;
          op_q    <= OP_ADD;
        end else if (advance) begin
          a_q     <= a_d;
          b_q     <= b_d;
          done_q  <= done_d;
          carry_q <= cout;
          op_q    <= op_d;
        end
      end
    end else begin : g_last
      logic                  n;
      logic                  c;
      logic                  v;
      logic [DATA_WIDTH-1:0] res_d;
      logic [DATA_WIDTH-1:0] res_q;

      assign n = done_d[DATA_WIDTH-1];
      assign c = cout;
      assign v = cmsb ^ cout;

      always_comb begin
        res_d = done_d;
        if (op_is_cmp(op_d)) begin
          res_d    = '0;
          res_d[0] = (op_d == OP_SLT) ? (n ^ v) : ~c;
        end
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          res_q <= '0;
        end else if (advance) begin
          res_q <= res_d;
        end
      end

`ifdef ADDSUB_PIPE_FLAGS_EN
      addsub_flags_t flags_d;
      addsub_flags_t flags_q;

      assign flags_d = {~|done_d, n, c, v};

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          flags_q <= '0;
        end else if (advance) begin
          flags_q <= flags_d;
        end
      end
`endif
    end
  end

  assign out_valid = g_stage[STAGES-1].valid_q;
  assign result    = out_valid ? g_stage[STAGES-1].g_last.res_q : '0;

`ifdef ADDSUB_PIPE_FLAGS_EN
  addsub_flags_t flags_out;

  assign flags_out = out_valid ? g_stage[STAGES-1].g_last.flags_q : '0;
  assign flag_z    = flags_out.z;
  assign flag_n    = flags_out.n;
  assign flag_c    = flags_out.c;
  assign flag_v    = flags_out.v;
`else
  assign flag_z = 1'b0;
  assign flag_n = 1'b0;
  assign flag_c = 1'b0;
  assign flag_v = 1'b0;
`endif

endmodule

// File: tb/tb_addsub_pipe.sv
// tb/tb_addsub_pipe.sv - directed checks of addsub_pipe at 8/2, 16/4, 32/4 and 1/1 configurations
module tb_addsub_pipe;
  import addsub_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        out_ready;
  addsub_op_e  op_r;
  logic [31:0] a_r;
  logic [31:0] b_r;
  int          dut_sel;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  logic       iv8, ir8, ov8, fz8, fn8, fc8, fv8;
  logic [7:0] res8;
  logic       iv16, ir16, ov16, fz16, fn16, fc16, fv16;
  logic [15:0] res16;
  logic       iv32, ir32, ov32, fz32, fn32, fc32, fv32;
  logic [31:0] res32;
  logic       iv1, ir1, ov1, fz1, fn1, fc1, fv1;
  logic [0:0] res1;

  assign iv8  = in_valid && (dut_sel == 0);
  assign iv16 = in_valid && (dut_sel == 1);
  assign iv32 = in_valid && (dut_sel == 2);
  assign iv1  = in_valid && (dut_sel == 3);

  addsub_pipe #(.DATA_WIDTH(8), .STAGES(2)) u_dut8 (
    .clk(clk), .reset(reset), .in_valid(iv8), .in_ready(ir8), .op(op_r),
    .src_a(a_r[7:0]), .src_b(b_r[7:0]), .out_valid(ov8), .out_ready(out_ready),
    .result(res8), .flag_z(fz8), .flag_n(fn8), .flag_c(fc8), .flag_v(fv8));

  addsub_pipe #(.DATA_WIDTH(16), .STAGES(4)) u_dut16 (
    .clk(clk), .reset(reset), .in_valid(iv16), .in_ready(ir16), .op(op_r),
    .src_a(a_r[15:0]), .src_b(b_r[15:0]), .out_valid(ov16), .out_ready(out_ready),
    .result(res16), .flag_z(fz16), .flag_n(fn16), .flag_c(fc16), .flag_v(fv16));

  addsub_pipe #(.DATA_WIDTH(32), .STAGES(4)) u_dut32 (
    .clk(clk), .reset(reset), .in_valid(iv32), .in_ready(ir32), .op(op_r),
    .src_a(a_r), .src_b(b_r), .out_valid(ov32), .out_ready(out_ready),
    .result(res32), .flag_z(fz32), .flag_n(fn32), .flag_c(fc32), .flag_v(fv32));

  addsub_pipe #(.DATA_WIDTH(1), .STAGES(1)) u_dut1 (
    .clk(clk), .reset(reset), .in_valid(iv1), .in_ready(ir1), .op(op_r),
    .src_a(a_r[0:0]), .src_b(b_r[0:0]), .out_valid(ov1), .out_ready(out_ready),
    .result(res1), .flag_z(fz1), .flag_n(fn1), .flag_c(fc1), .flag_v(fv1));

  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_res;
  logic [3:0]  s_flags;

  always_comb begin
    s_valid = 1'b0;
    s_ready = 1'b0;
    s_res   = '0;
    s_flags = '0;
    case (dut_sel)
      0: begin s_valid = ov8;  s_ready = ir8;  s_res = {24'b0, res8};  s_flags = {fz8, fn8, fc8, fv8}; end
      1: begin s_valid = ov16; s_ready = ir16; s_res = {16'b0, res16}; s_flags = {fz16, fn16, fc16, fv16}; end
      2: begin s_valid = ov32; s_ready = ir32; s_res = res32;          s_flags = {fz32, fn32, fc32, fv32}; end
      3: begin s_valid = ov1;  s_ready = ir1;  s_res = {31'b0, res1};  s_flags = {fz1, fn1, fc1, fv1}; end
      default: ;
    endcase
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Flags {z,n,c,v} only exist in the flags build; otherwise they must read 0.
  function automatic logic [3:0] fexp(input logic [3:0] f);
`ifdef ADDSUB_PIPE_FLAGS_EN
    return f;
`else
    return 4'b0000;
`endif
  endfunction

  task automatic run_op(input string tag, input int sel, input addsub_op_e o,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] er, input logic [3:0] ef, input int lat);
    int cyc;
    @(negedge clk);
    dut_sel   = sel;
    op_r      = o;
    a_r       = a;
    b_r       = b;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    #1;
    check_eq({tag, "_in_ready"}, {31'b0, s_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    cyc = 1;
    while (!s_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check_eq({tag, "_latency"}, cyc, lat);
    check_eq({tag, "_result"}, s_res, er);
    check_eq({tag, "_flags"}, {28'b0, s_flags}, {28'b0, fexp(ef)});
  endtask

  addsub_op_e  t4_op  [8] = '{OP_ADD, OP_SUB, OP_ADD, OP_SLT, OP_SLTU, OP_ADD, OP_SUB, OP_ADD};
  logic [31:0] t4_a   [8] = '{32'h0000_0001, 32'h1000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                              32'hFFFF_FFFF, 32'h1234_5678, 32'h0000_0000, 32'h00FF_00FF};
  logic [31:0] t4_b   [8] = '{32'h0000_0002, 32'h0000_0001, 32'h0000_0001, 32'h0000_0001,
                              32'h0000_0001, 32'h1111_1111, 32'h0000_0001, 32'h0001_0001};
  logic [31:0] t4_exp [8] = '{32'h0000_0003, 32'h0FFF_FFFF, 32'h0000_0000, 32'h0000_0001,
                              32'h0000_0000, 32'h2345_6789, 32'hFFFF_FFFF, 32'h0100_0100};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] exp_q[$];
    logic [31:0] held;
    logic [31:0] e;
    int          idx;
    int          got;
    int          stale;
    logic        stall;

    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    op_r      = OP_ADD;
    a_r       = '0;
    b_r       = '0;
    dut_sel   = 0;
    held      = '0;

    for (int s = 0; s < 4; s++) begin
      dut_sel = s;
      #1;
      check_eq($sformatf("reset_valid%0d", s), {31'b0, s_valid}, 32'd0);
      check_eq($sformatf("reset_result%0d", s), s_res, 32'd0);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;

    run_op("t1_add",    0, OP_ADD,  32'h0A,   32'h05,   32'h0F,   4'b0000, 2);
    run_op("t2_sub_c",  1, OP_SUB,  32'h00AA, 32'h0055, 32'h0055, 4'b0010, 4);
    run_op("t2_sub_n",  1, OP_SUB,  32'h0005, 32'h000A, 32'hFFFB, 4'b0100, 4);
    run_op("t2_sub_z",  1, OP_SUB,  32'h1234, 32'h1234, 32'h0000, 4'b1010, 4);
    run_op("t3_add_v",  0, OP_ADD,  32'h7F,   32'h01,   32'h80,   4'b0101, 2);
    run_op("t3_slt",    0, OP_SLT,  32'h80,   32'h01,   32'h01,   4'b0011, 2);
    run_op("t3_sltu",   0, OP_SLTU, 32'h80,   32'h01,   32'h00,   4'b0011, 2);
    run_op("t3_add_zc", 0, OP_ADD,  32'hFF,   32'h01,   32'h00,   4'b1010, 2);

    // Back-to-back stream with a three-cycle output stall once results are flowing.
    dut_sel = 2;
    idx = 0;
    got = 0;
    for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
      @(negedge clk);
      stall     = (cyc >= 6 && cyc < 9);
      out_ready = !stall;
      in_valid  = (idx < 8);
      if (idx < 8) begin
        op_r = t4_op[idx];
        a_r  = t4_a[idx];
        b_r  = t4_b[idx];
      end
      #1;
      if (stall && s_valid) begin
        check_eq("t4_in_ready_stall", {31'b0, s_ready}, 32'd0);
        if (cyc == 6) held = s_res;
        else check_eq("t4_hold", s_res, held);
      end
      if (s_valid && out_ready) begin
        e = 'x;
        if (exp_q.size() > 0) e = exp_q.pop_front();
        check_eq($sformatf("t4_res%0d", got), s_res, e);
        got++;
      end
      if (in_valid && s_ready) begin
        exp_q.push_back(t4_exp[idx]);
        idx++;
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check_eq("t4_count", got, 8);

    // Reset with three ops in flight, the oldest already at the output.
    @(negedge clk);
    dut_sel = 2;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      op_r     = OP_ADD;
      a_r      = i;
      b_r      = 32'd10;
      @(negedge clk);
    end
    in_valid = 1'b0;
    @(negedge clk);
    #1;
    check_eq("t5_pre_valid", {31'b0, s_valid}, 32'd1);
    reset = 1'b1;
    #1;
    check_eq("t5_rst_valid", {31'b0, s_valid}, 32'd0);
    check_eq("t5_rst_result", s_res, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    stale = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (s_valid) stale++;
    end
    check_eq("t5_no_stale", stale, 0);
    run_op("t5_add", 2, OP_ADD, 32'd1, 32'd2, 32'd3, 4'b0000, 4);

    run_op("t6_sub10", 3, OP_SUB, 32'd1, 32'd0, 32'd1, 4'b0110, 1);
    run_op("t6_sub01", 3, OP_SUB, 32'd0, 32'd1, 32'd1, 4'b0101, 1);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
